// File: rtl/fifo_stream_reader.sv
// Purpose: issues reads to a non-fallthrough FIFO and re-presents the words as a valid/ready stream.
// Latency: 2 cycles from fifo_empty falling (with an empty buffer) to out_valid; 1 word/cycle sustained.
// Backpressure: a 2-entry holding buffer absorbs the read latency; reads stop once buffer plus in-flight reaches 2.
module fifo_stream_reader #(
  parameter int WIDTH       = 72,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic                   enable,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] words_out,
  output logic [1:0]             buf_count
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic             inflight;
  logic             pop;
  logic [2:0]       occ_next;
  logic [1:0]       remain;

  assign out_valid = (buf_count != 2'd0);
  assign out_data  = head_q;
  assign pop       = out_valid & out_ready;

  // Occupancy after this edge: buffered words plus the word landing now, minus the one leaving.
  // pop implies buf_count >= 1, so the 3-bit result never underflows.
  assign occ_next  = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};

  // Words left in the buffer once this cycle's pop is taken out; selects where a capture lands.
  assign remain    = buf_count - {1'b0, pop};

  // A read is only issued if its word will find a free slot next cycle; never on an empty FIFO,
  // and never while reset is held so the FIFO sees no strobe during its own reset.
  assign fifo_rd_en = reset & enable & ~fifo_empty & (occ_next < 3'd2);

  // Control state: in-flight flag, occupancy and delivered-word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight  <= 1'b0;
      buf_count <= 2'd0;
      words_out <= '0;
    end else begin
      inflight  <= fifo_rd_en;
      buf_count <= occ_next[1:0];
      if (pop) begin
        words_out <= words_out + COUNT_WIDTH'(1);
      end
    end
  end

  // Holding buffer: pop shifts tail into head; a captured word fills the first slot left free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (pop && (buf_count == 2'd2)) begin
        head_q <= tail_q;
      end
      if (inflight) begin
        if (remain == 2'd0) begin
          head_q <= fifo_dout;
        end else begin
          tail_q <= fifo_dout;
        end
      end
    end
  end

`ifndef SYNTHESIS
  // A capture into a full buffer with no pop would lose a word; the read-issue rule forbids it.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(inflight && !pop && (buf_count == 2'd2)))
        else $error("fifo_stream_reader: holding buffer overflow");
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural non-fallthrough FIFO in front, scoreboard behind.
// Stimulus pushes words into the FIFO model and the expected-word queue; a negedge monitor
// pops and compares on every output handshake, while directed checks cover timing and reset.
module tb_fifo_stream_reader;
  localparam int W  = 72;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          enable;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] words_out;
  logic [1:0]    buf_count;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0]  mem [0:63];
  int            wp = 0;
  int            rp;
  logic [W-1:0]  exp_q [$];
  logic [CW-1:0] exp_words;

  fifo_stream_reader #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .enable     (enable),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .words_out  (words_out),
    .buf_count  (buf_count)
  );

  always #5 clk = ~clk;

  // Non-fallthrough FIFO model: data appears one clock after the read strobe.
  assign fifo_empty = (wp == rp);
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rp        <= 0;
      fifo_dout <= '0;
    end else if (fifo_rd_en) begin
      fifo_dout <= mem[rp % 64];
      rp        <= rp + 1;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    mem[wp % 64] = d;
    wp = wp + 1;
    exp_q.push_back(d);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) fail_now(name);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    wp    = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
  endtask

  // Monitor: every handshake must deliver the next expected word with the matching count.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      exp_words = '0;
    end else begin
      if (fifo_rd_en) check("rd_on_empty", W'(fifo_empty), W'(0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %0h, expected none", out_data);
        end else begin
          check("stream_data", out_data, exp_q.pop_front());
          check("words_out_seq", W'(words_out), W'(exp_words));
          exp_words = exp_words + 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic pat [5];
    int   k;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Power-on reset
    reset     = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b0;
    #1 reset  = 1'b0;
    #2;
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_data", out_data, W'(0));
    check("rst_words", W'(words_out), W'(0));
    check("rst_bufcnt", W'(buf_count), W'(0));
    check("rst_rd_en", W'(fifo_rd_en), W'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Streaming: 8 words, continuously ready
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(W'(i));
    #1;
    for (int c = 0; c <= 10; c++) begin
      check("stream_rd_en", W'(fifo_rd_en), W'(c < 8));
      check("stream_valid", W'(out_valid), W'(c >= 2 && c < 10));
      tick();
    end
    check("stream_words", W'(words_out), W'(8));

    // Backpressure: 5 words, consumer stalled
    out_ready = 1'b0;
    for (int i = 11; i <= 15; i++) push(W'(i));
    #1;
    repeat (6) tick();
    check("bp_bufcnt", W'(buf_count), W'(2));
    check("bp_head", out_data, W'(11));
    check("bp_depth", W'(wp - rp), W'(3));
    check("bp_rd_en", W'(fifo_rd_en), W'(0));
    repeat (2) tick();
    check("bp_head_held", out_data, W'(11));
    out_ready = 1'b1;
    #1;
    for (int c = 0; c <= 5; c++) begin
      check("bp_nogap", W'(out_valid), W'(c < 5));
      tick();
    end
    check("bp_words", W'(words_out), W'(13));

    // Asynchronous reset mid-stream with a full buffer
    out_ready = 1'b0;
    push(W'(49));
    push(W'(50));
    push(W'(51));
    repeat (5) tick();
    check("mid_bufcnt", W'(buf_count), W'(2));
    #2;
    reset = 1'b0;
    wp    = 0;
    #1;
    check("mid_rst_valid", W'(out_valid), W'(0));
    check("mid_rst_data", out_data, W'(0));
    check("mid_rst_words", W'(words_out), W'(0));
    check("mid_rst_bufcnt", W'(buf_count), W'(0));
    check("mid_rst_rd_en", W'(fifo_rd_en), W'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Latency: single word after release
    out_ready = 1'b0;
    push(W'(8'hA5));
    #1;
    check("lat_rd_en_n", W'(fifo_rd_en), W'(1));
    tick();
    check("lat_rd_en_n1", W'(fifo_rd_en), W'(0));
    check("lat_valid_n1", W'(out_valid), W'(0));
    tick();
    check("lat_valid_n2", W'(out_valid), W'(1));
    check("lat_data_n2", out_data, W'(8'hA5));
    out_ready = 1'b1;
    wait_drain("lat_drain");
    check("lat_words", W'(words_out), W'(1));

    // Toggling ready: pattern 1,0,1,1,0 over 10 words
    for (int i = 21; i <= 30; i++) push(W'(i));
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      out_ready = pat[k % 5];
      #1;
      check("tog_bufcnt_le2", W'(buf_count <= 2'd2), W'(1));
      tick();
      k++;
    end
    if (k >= 100) fail_now("tog_drain");
    out_ready = 1'b1;
    wait_drain("tog_final");
    check("tog_words", W'(words_out), W'(11));

    // Enable gating: drop enable right after a read issues
    out_ready = 1'b1;
    push(W'(8'h77));
    push(W'(8'h78));
    #1;
    check("en_rd_first", W'(fifo_rd_en), W'(1));
    tick();
    enable = 1'b0;
    #1;
    check("en_rd_off", W'(fifo_rd_en), W'(0));
    for (int c = 0; c < 4; c++) begin
      tick();
      check("en_rd_held", W'(fifo_rd_en), W'(0));
    end
    check("en_inflight_delivered", W'(exp_q.size()), W'(1));
    check("en_fifo_nonempty", W'(fifo_empty), W'(0));
    enable = 1'b1;
    wait_drain("en_drain");
    check("en_words", W'(words_out), W'(13));

    // Counter wrap: 17 pops on a 4-bit counter
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(W'(256 + i));
    wait_drain("wrap_drain");
    check("wrap_words", W'(words_out), W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side companion to the team's non-fallthrough small FIFO, where read data appears on the FIFO's data output one clock after the read-enable. The block issues FIFO reads, absorbs the one-cycle read latency in a 2-entry holding buffer, and presents the words as a valid/ready stream. Sustained throughput with a continuously ready consumer is one word per cycle. It sits between any small FIFO instance and a downstream consumer, such as a barrier-chain message parser.

Parameters:
WIDTH, 72, data width; must match the attached FIFO width.
COUNT_WIDTH, 32, width of the delivered-word counter.

Ports:
clk  in  1  single clock; all state changes on its rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
fifo_dout  in  WIDTH  FIFO read data; valid the cycle after fifo_rd_en was high.
fifo_empty  in  1  FIFO empty flag.
fifo_rd_en  out  1  FIFO read strobe; combinational.
enable  in  1  when 0, no new FIFO reads are issued; buffered words still drain.
out_data  out  WIDTH  head word of the holding buffer.
out_valid  out  1  out_data holds a valid word.
out_ready  in  1  consumer accepts out_data this cycle.
words_out  out  COUNT_WIDTH  count of completed output handshakes.
buf_count  out  2  current holding-buffer occupancy, 0..2.

Behaviour:
- Reset (reset==0, asynchronous):
  - buf_count=0, inflight=0, out_valid=0, out_data=0, words_out=0.
  - fifo_rd_en=0 while reset is asserted.
  - Release is synchronous to clk.
  - The FIFO must be reset in the same window; any in-flight read word is discarded.
- Internal state:
  - 2-entry holding buffer: head register, tail register, buf_count.
  - 1-bit inflight flag = fifo_rd_en registered from the previous cycle.
- pop = out_valid & out_ready.
- Read issue, combinational:
  - fifo_rd_en = enable & ~fifo_empty & ((buf_count + inflight - pop) < 2).
  - Evaluate at 2-bit-plus-carry width; the subtraction never underflows because pop implies buf_count>=1.
  - A read is never issued on an empty FIFO.
  - Buffer overflow is impossible by construction; add a sim-only check that errors if it occurs.
- Capture:
  - If inflight==1, fifo_dout is written into the buffer this edge.
  - Write goes to the head if the buffer will be empty after pop, else to the tail.
- Pop:
  - Tail shifts into head.
  - Simultaneous pop and capture with buf_count==1: the captured word becomes the head.
  - Simultaneous pop and capture with buf_count==2: tail goes to head, captured word goes to tail.
  - buf_count next = buf_count + inflight - pop.
- out_valid = (buf_count != 0); registered state, no combinational path from out_ready.
- out_data: held stable while out_valid & ~out_ready.
- Latency:
  - fifo_empty falls in cycle N, with enable=1 and the buffer empty.
  - fifo_rd_en=1 in cycle N; inflight=1 in cycle N+1; out_valid=1 in cycle N+2.
- Throughput: with out_ready held high and the FIFO non-empty, one word per cycle, reads back-to-back.
- Backpressure: with out_ready=0, at most 2 reads complete and then fifo_rd_en stays low; no word is lost or duplicated.
- enable falling: a read already in flight is still captured; the buffer keeps draining.
- Word order is strictly FIFO order.
- words_out:
  - Increments on each pop.
  - Wraps modulo 2^COUNT_WIDTH with no saturation.

Test Plan:
- Reset and latency:
  - Assert reset=0 mid-stream with buf_count=2 -> all outputs zero immediately, with no clock edge needed.
  - After release, write 0xA5 into the FIFO -> fifo_rd_en high for exactly 1 cycle; out_valid=1 two cycles later with out_data=0xA5.
- Streaming:
  - Preload 8 words 1..8, out_ready=1 -> fifo_rd_en high 8 consecutive cycles.
  - out_valid high 8 consecutive cycles, data 1..8 in order; words_out=8.
- Backpressure:
  - Preload 5 words, out_ready=0 -> exactly 2 reads, buf_count=2, out_data=1 held stable, FIFO depth 3.
  - Then out_ready=1 -> words 1..5 delivered in order, no gaps after the first.
- Toggling ready:
  - Drive out_ready with pattern 1,0,1,1,0 over 10 words -> every word delivered once, in order.
  - buf_count never exceeds 2; no FIFO empty-read error.
- Enable gating:
  - Deassert enable the cycle after a read issues -> that word still appears on out_data.
  - No further fifo_rd_en until enable=1.
- Counter wrap:
  - Run with COUNT_WIDTH=4 and 17 pops -> words_out reads 1.
